// File: rtl/mmio_router_pkg.sv
// Shared widths, FSM encoding and default window map for the MMIO router.
package mmio_router_pkg;

  localparam int ADDR_W = 32;
  localparam int XLEN   = 32;

  typedef enum logic [1:0] {
    MMIO_ST_IDLE = 2'd0,
    MMIO_ST_WAIT = 2'd1,
    MMIO_ST_RESP = 2'd2
  } mmio_state_e;

  // Window i lives at bits [i*ADDR_W +: ADDR_W]: RAM, DMA, timer block, external.
  localparam logic [4*ADDR_W-1:0] MMIO_DEF_SLV_BASE =
    {32'h8000_0000, 32'h4000_1000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [4*ADDR_W-1:0] MMIO_DEF_SLV_MASK =
    {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_FFE0, 32'hFFFF_0000};

  localparam logic [XLEN-1:0] MMIO_ERR_RDATA = 32'hDEAD_BEEF;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_addr_match.sv
// Address window decoder: mask/compare per window, lowest index wins on overlap.
module mmio_addr_match
  import mmio_router_pkg::*;
#(
  parameter int                         N_SLAVES = 4,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = MMIO_DEF_SLV_BASE,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = MMIO_DEF_SLV_MASK
) (
  input  logic [ADDR_W-1:0]                addr,
  output logic [N_SLAVES-1:0]              onehot,
  output logic [idx_width(N_SLAVES)-1:0]   idx,
  output logic                             unmapped
);

  localparam int IDX_W = idx_width(N_SLAVES);

  logic [N_SLAVES-1:0] hit;

  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_hit
    assign hit[gi] = ((addr & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W]);
  end

  // Walk from the top down so the lowest matching index is the last one written.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

  assign unmapped = ~|hit;

endmodule

// File: rtl/mmio_router.sv
// Routes one CPU data-memory request to one of N_SLAVES windows with a ready
// handshake, bus error on unmapped addresses, slave timeout and a sticky fault record.
module mmio_router
  import mmio_router_pkg::*;
#(
  parameter int                         N_SLAVES  = 4,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE  = MMIO_DEF_SLV_BASE,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK  = MMIO_DEF_SLV_MASK,
  parameter int                         TIMEOUT   = 256,
  parameter logic [XLEN-1:0]            ERR_RDATA = MMIO_ERR_RDATA
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_mem_req,
  input  logic                       cpu_mem_we,
  input  logic [ADDR_W-1:0]          cpu_mem_addr,
  input  logic [XLEN-1:0]            cpu_mem_wdata,
  output logic [XLEN-1:0]            cpu_mem_rdata,
  output logic                       cpu_mem_ready,
  output logic                       cpu_mem_err,
  output logic [N_SLAVES-1:0]        slv_req,
  output logic                       slv_we,
  output logic [ADDR_W-1:0]          slv_addr,
  output logic [XLEN-1:0]            slv_wdata,
  input  logic [N_SLAVES*XLEN-1:0]   slv_rdata,
  input  logic [N_SLAVES-1:0]        slv_ready,
  output logic                       fault_valid,
  output logic [ADDR_W-1:0]          fault_addr,
  output logic                       fault_timeout,
  input  logic                       fault_clr
);

  localparam int IDX_W = idx_width(N_SLAVES);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0] TO_LIMIT = (CNT_W + 1)'(TIMEOUT);

  mmio_state_e          state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 we_q, we_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [N_SLAVES-1:0]  sel_q, sel_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [XLEN-1:0]      rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 fault_valid_q, fault_valid_d;
  logic [ADDR_W-1:0]    fault_addr_q, fault_addr_d;
  logic                 fault_timeout_q, fault_timeout_d;

  logic [N_SLAVES-1:0]  match_onehot;
  logic [IDX_W-1:0]     match_idx;
  logic                 match_unmapped;
  logic                 fault_set;
  logic [ADDR_W-1:0]    fault_set_addr;
  logic                 fault_set_to;
  logic                 sel_ready;
  logic [XLEN-1:0]      sel_rdata;
  logic [CNT_W:0]       cnt_inc;

  mmio_addr_match #(
    .N_SLAVES (N_SLAVES),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_match (
    .addr     (cpu_mem_addr),
    .onehot   (match_onehot),
    .idx      (match_idx),
    .unmapped (match_unmapped)
  );

  assign sel_ready = slv_ready[idx_q];
  assign sel_rdata = slv_rdata[idx_q*XLEN +: XLEN];
  assign cnt_inc   = {1'b0, cnt_q} + (CNT_W + 1)'(1);

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    sel_d          = sel_q;
    idx_d          = idx_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    cnt_d          = cnt_q;
    fault_set      = 1'b0;
    fault_set_addr = addr_q;
    fault_set_to   = 1'b0;

    case (state_q)
      MMIO_ST_IDLE: begin
        if (cpu_mem_req) begin
          addr_d  = cpu_mem_addr;
          we_d    = cpu_mem_we;
          wdata_d = cpu_mem_wdata;
          sel_d   = match_onehot;
          idx_d   = match_idx;
          if (match_unmapped) begin
            err_d          = 1'b1;
            rdata_d        = ERR_RDATA;
            fault_set      = 1'b1;
            fault_set_addr = cpu_mem_addr;
            state_d        = MMIO_ST_RESP;
          end else begin
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = MMIO_ST_WAIT;
          end
        end
      end

      MMIO_ST_WAIT: begin
        // Ready is checked first so a completion in the timeout cycle still succeeds.
        if (sel_ready) begin
          rdata_d = we_q ? '0 : sel_rdata;
          err_d   = 1'b0;
          state_d = MMIO_ST_RESP;
        end else begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
          if ((TIMEOUT > 0) && (cnt_inc == TO_LIMIT)) begin
            rdata_d      = ERR_RDATA;
            err_d        = 1'b1;
            fault_set    = 1'b1;
            fault_set_to = 1'b1;
            state_d      = MMIO_ST_RESP;
          end
        end
      end

      MMIO_ST_RESP: state_d = MMIO_ST_IDLE;

      default: state_d = MMIO_ST_IDLE;
    endcase
  end

  always_comb begin
    fault_valid_d   = fault_set | (fault_valid_q & ~fault_clr);
    fault_addr_d    = fault_set ? fault_set_addr : fault_addr_q;
    fault_timeout_d = fault_set ? fault_set_to   : fault_timeout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= MMIO_ST_IDLE;
      addr_q          <= '0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      sel_q           <= '0;
      idx_q           <= '0;
      rdata_q         <= '0;
      err_q           <= 1'b0;
      cnt_q           <= '0;
      fault_valid_q   <= 1'b0;
      fault_addr_q    <= '0;
      fault_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      we_q            <= we_d;
      wdata_q         <= wdata_d;
      sel_q           <= sel_d;
      idx_q           <= idx_d;
      rdata_q         <= rdata_d;
      err_q           <= err_d;
      cnt_q           <= cnt_d;
      fault_valid_q   <= fault_valid_d;
      fault_addr_q    <= fault_addr_d;
      fault_timeout_q <= fault_timeout_d;
    end
  end

  // The slave bus is driven straight from the latches so it cannot move during WAIT.
  assign slv_req       = (state_q == MMIO_ST_WAIT) ? sel_q : '0;
  assign slv_we        = we_q;
  assign slv_addr      = addr_q;
  assign slv_wdata     = wdata_q;
  assign cpu_mem_ready = (state_q == MMIO_ST_RESP);
  assign cpu_mem_rdata = cpu_mem_ready ? rdata_q : '0;
  assign cpu_mem_err   = cpu_mem_ready & err_q;
  assign fault_valid   = fault_valid_q;
  assign fault_addr    = fault_addr_q;
  assign fault_timeout = fault_timeout_q;

endmodule

// File: tb/tb_mmio_router.sv
// Randomised bench for mmio_router: the bench plays CPU and all slaves and
// predicts every response from an address-range model of the window map.
module tb_mmio_router;
  import mmio_router_pkg::*;

  localparam int TO_CYC = 8;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
  localparam logic [4*ADDR_W-1:0] OV_BASE =
    {32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [4*ADDR_W-1:0] OV_MASK =
    {32'hF000_0000, 32'hFFFF_FFE0, 32'hFFFF_FFE0, 32'hFFFF_0000};

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cpu_mem_req, cpu_mem_we, fault_clr, ov_en;
  logic [31:0]  cpu_mem_addr, cpu_mem_wdata;
  logic [127:0] slv_rdata;
  logic [3:0]   slv_ready;

  logic [31:0]  cpu_mem_rdata, slv_addr, slv_wdata, fault_addr;
  logic         cpu_mem_ready, cpu_mem_err, slv_we, fault_valid, fault_timeout;
  logic [3:0]   slv_req;

  logic [31:0]  ov_cpu_mem_rdata, ov_slv_addr, ov_slv_wdata, ov_fault_addr;
  logic         ov_cpu_mem_ready, ov_cpu_mem_err, ov_slv_we, ov_fault_valid, ov_fault_timeout;
  logic [3:0]   ov_slv_req;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;
  logic [3:0]  ov_or;
  logic [31:0] sl_ram  [int];
  logic [31:0] ref_ram [int];

  always #5 clk = ~clk;

  mmio_router #(.N_SLAVES(4), .TIMEOUT(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_mem_req(cpu_mem_req), .cpu_mem_we(cpu_mem_we),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_rdata(cpu_mem_rdata), .cpu_mem_ready(cpu_mem_ready), .cpu_mem_err(cpu_mem_err),
    .slv_req(slv_req), .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata), .slv_ready(slv_ready),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_timeout(fault_timeout),
    .fault_clr(fault_clr)
  );

  mmio_router #(.N_SLAVES(4), .SLV_BASE(OV_BASE), .SLV_MASK(OV_MASK), .TIMEOUT(TO_CYC)) dut_ov (
    .clk(clk), .rst_n(rst_n),
    .cpu_mem_req(cpu_mem_req & ov_en), .cpu_mem_we(cpu_mem_we),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_rdata(ov_cpu_mem_rdata), .cpu_mem_ready(ov_cpu_mem_ready), .cpu_mem_err(ov_cpu_mem_err),
    .slv_req(ov_slv_req), .slv_we(ov_slv_we), .slv_addr(ov_slv_addr), .slv_wdata(ov_slv_wdata),
    .slv_rdata(slv_rdata), .slv_ready(slv_ready),
    .fault_valid(ov_fault_valid), .fault_addr(ov_fault_addr), .fault_timeout(ov_fault_timeout),
    .fault_clr(fault_clr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Window map expressed as plain address ranges.
  function automatic int ref_window(input logic [31:0] a);
    if (a <= 32'h0000_FFFF) return 0;
    if (a >= 32'h4000_0000 && a <= 32'h4000_001F) return 1;
    if (a >= 32'h4000_1000 && a <= 32'h4000_1FFF) return 2;
    if (a >= 32'h8000_0000 && a <= 32'h8FFF_FFFF) return 3;
    return -1;
  endfunction

  function automatic logic [31:0] periph_data(input int s, input logic [31:0] a);
    case (s)
      1:       return 32'hD00D_0000 | {29'd0, a[4:2]};
      2:       return 32'h5A5A_0000 | {16'd0, a[15:0]};
      default: return a ^ 32'h0F0F_0F0F;
    endcase
  endfunction

  function automatic logic [31:0] ram_init(input int k);
    return (32'(k) * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic do_txn(input logic [31:0] a, input bit w, input logic [31:0] d,
                        input int waits, input bit clr_with);
    int s, lat, lat_exp, req_cycles, req_exp, bad_sel, bad_bus, k;
    bit exp_err, exp_to, done;
    logic [31:0] exp_rd, rv;
    logic [3:0] oh;
    s       = ref_window(a);
    oh      = (s >= 0) ? 4'(1 << s) : 4'b0000;
    exp_to  = (s >= 0) && (waits >= TO_CYC);
    exp_err = (s < 0) || exp_to;
    if (s < 0) begin
      lat_exp = 1; req_exp = 0;
    end else if (exp_to) begin
      lat_exp = TO_CYC + 1; req_exp = TO_CYC;
    end else begin
      lat_exp = waits + 2; req_exp = waits + 1;
    end
    k = int'(a[15:2]);
    if (exp_err)     exp_rd = ERR_WORD;
    else if (w)      exp_rd = 32'h0;
    else if (s == 0) exp_rd = ref_ram.exists(k) ? ref_ram[k] : ram_init(k);
    else             exp_rd = periph_data(s, a);
    if (w && s == 0 && !exp_to) ref_ram[k] = d;

    cpu_mem_req = 1'b1; cpu_mem_we = w; cpu_mem_addr = a; cpu_mem_wdata = d;
    fault_clr = clr_with;
    lat = 0; req_cycles = 0; bad_sel = 0; bad_bus = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      fault_clr = 1'b0;
      slv_ready = 4'b0000;
      slv_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (cpu_mem_ready) begin
        done = 1'b1;
      end else if (slv_req != 4'b0000) begin
        req_cycles++;
        if (slv_req !== oh) bad_sel++;
        if (slv_addr !== a || slv_we !== w || slv_wdata !== d) bad_bus++;
        if (ov_en && ov_slv_req != 4'b0000) begin
          ov_or = ov_or | ov_slv_req;
          if (ov_slv_addr !== a || ov_slv_we !== w || ov_slv_wdata !== d) bad_bus++;
        end
        if (s >= 0 && req_cycles == waits + 1) begin
          if (s == 0) begin
            if (w) sl_ram[int'(slv_addr[15:2])] = slv_wdata;
            rv = sl_ram.exists(int'(slv_addr[15:2])) ? sl_ram[int'(slv_addr[15:2])]
                                                      : ram_init(int'(slv_addr[15:2]));
          end else begin
            rv = periph_data(s, slv_addr);
          end
          slv_rdata[s*32 +: 32] = rv;
          slv_ready[s] = 1'b1;
        end
        slv_ready = slv_ready | (4'($urandom) & ~oh);
      end
    end

    check_val("latency", 32'(lat), 32'(lat_exp));
    check_val("err", 32'(cpu_mem_err), 32'(exp_err));
    check_val("rdata", cpu_mem_rdata, exp_rd);
    check_val("req_cycles", 32'(req_cycles), 32'(req_exp));
    check_val("sel_onehot", 32'(bad_sel), 32'd0);
    check_val("bus_stable", 32'(bad_bus), 32'd0);
    if (exp_err) begin
      check_val("fault_valid", 32'(fault_valid), 32'd1);
      check_val("fault_addr", fault_addr, a);
      check_val("fault_timeout", 32'(fault_timeout), 32'(exp_to));
    end
    if (ov_en) begin
      check_val("ov_ready", 32'(ov_cpu_mem_ready), 32'd1);
      check_val("ov_rdata", ov_cpu_mem_rdata, exp_rd);
      check_val("ov_err", 32'(ov_cpu_mem_err), 32'(exp_err));
    end
    $display("txn %0d addr=%h we=%0b waits=%0d err=%0b rdata=%h lat=%0d",
             n_txn, a, w, waits, cpu_mem_err, cpu_mem_rdata, lat);
    n_txn++;
    cpu_mem_req = 1'b0;
    slv_ready = 4'b0000;
    @(negedge clk);
    check_val("ready_pulse", 32'(cpu_mem_ready), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic        ready_seen;
    int          cls;
    cpu_mem_req = 1'b0; cpu_mem_we = 1'b0; cpu_mem_addr = '0; cpu_mem_wdata = '0;
    fault_clr = 1'b0; ov_en = 1'b0; slv_ready = '0; slv_rdata = '0; ov_or = '0;

    #1 rst_n = 1'b0;
    #1;
    check_val("rst_slv_req", 32'(slv_req), 32'd0);
    check_val("rst_ready", 32'(cpu_mem_ready), 32'd0);
    check_val("rst_err", 32'(cpu_mem_err), 32'd0);
    check_val("rst_rdata", cpu_mem_rdata, 32'd0);
    check_val("rst_fault_valid", 32'(fault_valid), 32'd0);
    check_val("rst_slv_addr", slv_addr, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // RAM zero-wait write then read back
    do_txn(32'h0000_0010, 1'b1, 32'h1234_5678, 0, 1'b0);
    do_txn(32'h0000_0010, 1'b0, 32'h0, 0, 1'b0);
    // DMA with 3 wait cycles, then just past the DMA window
    do_txn(32'h4000_001C, 1'b0, 32'h0, 3, 1'b0);
    do_txn(32'h4000_0020, 1'b0, 32'h0, 0, 1'b0);

    // Overlapping windows 1 and 2 on the second instance
    ov_en = 1'b1; ov_or = 4'b0000;
    do_txn(32'h4000_0004, 1'b0, 32'h0, 0, 1'b0);
    ov_en = 1'b0;
    check_val("ov_priority", 32'(ov_or), 32'h2);
    check_val("ov_no_fault", 32'(ov_fault_valid), 32'd0);
    check_val("ov_fault_addr", ov_fault_addr, 32'd0);
    check_val("ov_fault_to", 32'(ov_fault_timeout), 32'd0);

    // Timeout, then clear the sticky flag
    do_txn(32'h8000_0100, 1'b0, 32'h0, 100, 1'b0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check_val("clr_valid", 32'(fault_valid), 32'd0);
    check_val("clr_keeps_addr", fault_addr, 32'h8000_0100);
    check_val("clr_keeps_to", 32'(fault_timeout), 32'd1);
    // Ready in the same cycle the timeout would fire
    do_txn(32'h8000_0200, 1'b0, 32'h0, TO_CYC - 1, 1'b0);
    check_val("ready_wins_no_fault", 32'(fault_valid), 32'd0);
    // Fault and clear together: the fault wins
    do_txn(32'h2000_0000, 1'b1, 32'hCAFE_F00D, 0, 1'b1);

    // Reset in the middle of a slow access
    cpu_mem_req = 1'b1; cpu_mem_we = 1'b0; cpu_mem_addr = 32'h8000_0300; cpu_mem_wdata = '0;
    repeat (4) @(negedge clk);
    check_val("pre_rst_req", 32'(slv_req), 32'h8);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_slv_req", 32'(slv_req), 32'd0);
    check_val("mid_rst_ready", 32'(cpu_mem_ready), 32'd0);
    check_val("mid_rst_rdata", cpu_mem_rdata, 32'd0);
    check_val("mid_rst_fault_valid", 32'(fault_valid), 32'd0);
    check_val("mid_rst_fault_addr", fault_addr, 32'd0);
    check_val("mid_rst_slv_addr", slv_addr, 32'd0);
    cpu_mem_req = 1'b0;
    ready_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ready_seen = ready_seen | cpu_mem_ready;
    end
    check_val("mid_rst_no_ready", 32'(ready_seen), 32'd0);
    rst_n = 1'b1;
    do_txn(32'h0000_0010, 1'b0, 32'h0, 1, 1'b0);

    // Random traffic across all windows and some holes
    for (int i = 0; i < 500; i++) begin
      cls = $urandom_range(0, 5);
      case (cls)
        0, 5: a = {16'h0000, 8'h00, 2'b00, 4'($urandom_range(0, 15)), 2'b00};
        1:    a = 32'h4000_0000 | {27'd0, 3'($urandom), 2'b00};
        2:    a = 32'h4000_1000 | {20'd0, 10'($urandom), 2'b00};
        3:    a = {4'h8, 26'($urandom), 2'b00};
        default: a = ($urandom_range(0, 1) == 0) ? (32'h4000_0020 | {27'd0, 3'($urandom), 2'b00})
                                                 : (32'h2000_0000 | {16'd0, 16'($urandom)});
      endcase
      do_txn(a, 1'($urandom), $urandom, $urandom_range(0, 5), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_router.md
Name: mmio_router

Overview:
- Parametrised successor to the two-way RAM/DMA MMIO decoder: routes one CPU data-memory request to one of N_SLAVES address windows.
- Sits between the core's data-memory port and RAM plus MMIO peripherals (DMA, timer, UART, ...).
- Unlike the combinational two-way split, it tolerates multi-cycle slaves through a ready handshake.
- Returns a bus error for unmapped addresses and aborts with an error on slave timeout. Keeps a sticky record of the last fault.

Parameters:
- N_SLAVES, 4, number of slave windows (1..8).
- SLV_BASE, {32'h8000_0000, 32'h4000_1000, 32'h4000_0000, 32'h0000_0000}, packed N_SLAVES*`ADDR_W match values; slave i occupies bits [i*`ADDR_W +: `ADDR_W].
- SLV_MASK, {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_FFE0, 32'hFFFF_0000}, packed N_SLAVES*`ADDR_W masks.
- TIMEOUT, 256, maximum cycles in WAIT before abort; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on any error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- cpu_mem_req  in  1  request; held by the CPU until cpu_mem_ready
- cpu_mem_we  in  1  write enable
- cpu_mem_addr  in  `ADDR_W  byte address
- cpu_mem_wdata  in  `XLEN  write data
- cpu_mem_rdata  out  `XLEN  read data, valid while cpu_mem_ready
- cpu_mem_ready  out  1  one-cycle completion pulse
- cpu_mem_err  out  1  error qualifier, valid while cpu_mem_ready
- slv_req  out  N_SLAVES  one-hot request
- slv_we  out  1  shared write enable
- slv_addr  out  `ADDR_W  shared address
- slv_wdata  out  `XLEN  shared write data
- slv_rdata  in  N_SLAVES*`XLEN  per-slave read data
- slv_ready  in  N_SLAVES  per-slave completion
- fault_valid  out  1  sticky: a fault has occurred
- fault_addr  out  `ADDR_W  address of the most recent fault
- fault_timeout  out  1  1 = most recent fault was a timeout, 0 = unmapped
- fault_clr  in  1  clears fault_valid

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: every output is 0; the FSM is in IDLE; the timeout counter is 0.
- An assertion mid-transaction aborts the transaction and no response is issued.

Decode:
- hit[i] = ((cpu_mem_addr & SLV_MASK[i]) == SLV_BASE[i]).
- If several windows hit, the lowest index wins.
- No hit means unmapped.

FSM states: IDLE, WAIT, RESP.
- IDLE, cpu_mem_req=1:
  - Latch addr, we, wdata, the selected index and a one-hot select.
  - On a hit, go to WAIT. On unmapped, go to RESP with err=1, no slave is touched, and record the fault.
- WAIT:
  - slv_req = latched one-hot; slv_addr/we/wdata come from the latches and stay stable.
  - When slv_ready[sel] = 1: capture slv_rdata[sel], err=0, go to RESP. slv_ready of unselected slaves is ignored.
  - Otherwise the counter increments. When the counter reaches TIMEOUT (TIMEOUT>0) without ready: drop slv_req, err=1, record the fault with fault_timeout=1, go to RESP.
- RESP:
  - cpu_mem_ready=1 for exactly one cycle.
  - cpu_mem_rdata = captured data on reads, ERR_RDATA on errors, 0 on successful writes.
  - cpu_mem_err as set. Then go to IDLE.
- cpu_mem_req and its fields are ignored outside IDLE. A request still high in the cycle after RESP is treated as a new request.

Latency:
- Zero-wait slave: request sampled in cycle 0, slv_req in cycle 1, cpu_mem_ready in cycle 2.
- Unmapped: cpu_mem_ready in cycle 1.

Fault register:
- Each fault sets fault_valid and overwrites fault_addr and fault_timeout.
- fault_clr clears fault_valid only.
- A fault and fault_clr in the same cycle leave fault_valid=1 (set wins).

Timeout counter:
- Width $clog2(TIMEOUT+1).
- Cleared when entering WAIT.
- Never wraps.

Slave ready:
- slv_ready[sel] arriving in the same cycle the timeout fires counts as success; ready wins.

Decomposition:
- Add to defines.vh: MMIO_ST_IDLE/WAIT/RESP encodings, the default window constants, MMIO_ERR_RDATA.
- Sub-module mmio_addr_match (N_SLAVES, SLV_BASE, SLV_MASK): combinational hit vector, priority one-hot, index, unmapped flag.
- FSM, latches and fault register stay in mmio_router.

Test Plan:
- RAM slave, zero wait: write 0x0000_0010 = 0x1234_5678, then read it back. slv_req = 4'b0001 for one cycle each; ready in cycle 2; rdata = 0x1234_5678; err = 0.
- DMA slave, 3 wait cycles: read 0x4000_001C returns 0xD00D_0007, ready at cycle 5, addr stable throughout WAIT. Read 0x4000_0020 returns err=1, rdata=0xDEAD_BEEF, no slv_req, fault_addr=0x4000_0020, fault_timeout=0.
- Overlap priority: windows 1 and 2 both overridden to 0x4000_0000 / 0xFFFF_FFE0; read 0x4000_0004 selects slv_req = 4'b0010 only.
- Timeout with TIMEOUT=8: slave 3 never readies on 0x8000_0100. slv_req[3] is high for exactly 8 cycles, then cpu_mem_ready with err=1 and fault_timeout=1. Pulse fault_clr, then fault_valid=0.
- Reset mid-WAIT: assert rst_n=0 during a slow slave access. All outputs go to 0 immediately with no ready pulse; the next request after reset completes normally.
- Random: 500 requests with random address, we and 0-5 wait cycles. Check against a reference model: a single one-hot select or err, a single ready per request, and data integrity on the RAM window.
